// File: rtl/cv32e40p_pkg.sv
// Shared constants and types for the cv32e40p interrupt front-end.
package cv32e40p_pkg;

  // Default synchronizer depth for the interrupt gateway.
  localparam int unsigned IRQ_GW_SYNC_STAGES_DEFAULT = 2;

  // Interrupt lines implemented by the core.
  // These are the software, timer and external lines (3, 7, 11) plus the fast lines 16..31.
  localparam logic [31:0] IRQ_MASK = 32'hFFFF_0888;

  // Per-line trigger mode.
  typedef enum logic {
    IRQ_TRIG_LEVEL = 1'b0,
    IRQ_TRIG_EDGE  = 1'b1
  } irq_trig_e;

endpackage

// File: rtl/cv32e40p_irq_sync.sv
// Multi-bit flop synchronizer for asynchronous interrupt lines.
// Each bit is synchronized independently; there is no cross-bit coherence.
module cv32e40p_irq_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the raw lines through STAGES flops; reset clears the whole chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d;
      for (int s = 1; s < STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/cv32e40p_irq_gateway.sv
// Interrupt gateway: synchronizes external lines, turns edge lines into sticky
// pending bits (cleared by core ack or software), and passes level lines through.
module cv32e40p_irq_gateway
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 32,
  parameter int unsigned SYNC_STAGES = IRQ_GW_SYNC_STAGES_DEFAULT,
  parameter logic [31:0] GW_MASK     = IRQ_MASK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_raw_i,
  input  logic [NUM_IRQ-1:0] trig_edge_i,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_ack_id_i,
  input  logic               sw_set_i,
  input  logic               sw_clr_i,
  input  logic [4:0]         sw_id_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic [NUM_IRQ-1:0] overrun_o
);

  localparam logic [NUM_IRQ-1:0] LINE_MASK  = GW_MASK[NUM_IRQ-1:0];
  localparam int unsigned        ARM_CYCLES = SYNC_STAGES + 1;

  logic [NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] hist_q;
  logic [NUM_IRQ-1:0] trig_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] ovr_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] ovr_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] mode_chg;
  logic [2:0]         warm_q;
  logic               armed;

  // Masked lines enter the synchronizer as 0 so they read 0 everywhere downstream.
  cv32e40p_irq_sync #(
    .WIDTH  (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_raw_i & LINE_MASK),
    .q   (sync_q)
  );

  // After reset the synchronizer refills one cycle ahead of the history register.
  // Edge detection stays disarmed until both have caught up, so a line that was
  // already high across reset is never mistaken for a fresh rising edge.
  assign armed    = (warm_q == 3'(ARM_CYCLES));
  assign mode_chg = (trig_edge_i ^ trig_q) & LINE_MASK;
  assign rise     = sync_q & ~hist_q & ~mode_chg & {NUM_IRQ{armed}};

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    if (LINE_MASK[i]) begin : g_impl
      logic edge_line;
      logic set_hit;
      logic clr_hit;
      logic sw_clr_hit;

      assign edge_line  = (irq_trig_e'(trig_q[i]) == IRQ_TRIG_EDGE);
      assign sw_clr_hit = sw_clr_i && (sw_id_i == 5'(i));
      assign set_hit    = rise[i] || (sw_set_i && (sw_id_i == 5'(i)));
      assign clr_hit    = (irq_ack_i && (irq_ack_id_i == 5'(i))) || sw_clr_hit;

      // Set beats clear so an edge arriving with its own ack is not lost.
      assign pend_d[i] = (mode_chg[i] || !edge_line) ? 1'b0 :
                         set_hit                     ? 1'b1 :
                         clr_hit                     ? 1'b0 : pend_q[i];

      // Overrun only when an edge lands on a pending line that is not being cleared.
      assign ovr_d[i]  = (mode_chg[i] || !edge_line)      ? 1'b0 :
                         (rise[i] && pend_q[i] && !clr_hit) ? 1'b1 :
                         sw_clr_hit                        ? 1'b0 : ovr_q[i];
    end else begin : g_unimpl
      assign pend_d[i] = 1'b0;
      assign ovr_d[i]  = 1'b0;
    end
  end

  // Register history, trigger mode, pending/overrun state and the warm-up counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      trig_q <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
      warm_q <= '0;
    end else begin
      hist_q <= sync_q;
      trig_q <= trig_edge_i & LINE_MASK;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      if (!armed) begin
        warm_q <= warm_q + 3'd1;
      end
    end
  end

  assign irq_o     = (trig_q & pend_q) | (~trig_q & sync_q);
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_cv32e40p_irq_gateway.sv
// Self-checking bench for cv32e40p_irq_gateway: directed scenarios plus a
// randomized run against a behavioural model of the gateway rules.
module tb_cv32e40p_irq_gateway;

  localparam int          S        = 2;
  localparam logic [31:0] MASK_REF = 32'hFFFF_0888;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raw;
  logic [31:0] trig;
  logic        ack;
  logic [4:0]  ack_id;
  logic        sw_set;
  logic        sw_clr;
  logic [4:0]  sw_id;
  logic [31:0] irq;
  logic [31:0] ovr;
  logic [19:0] irq20;
  logic [19:0] ovr20;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cv32e40p_irq_gateway #(.NUM_IRQ(32), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_raw_i    (raw),
    .trig_edge_i  (trig),
    .irq_ack_i    (ack),
    .irq_ack_id_i (ack_id),
    .sw_set_i     (sw_set),
    .sw_clr_i     (sw_clr),
    .sw_id_i      (sw_id),
    .irq_o        (irq),
    .overrun_o    (ovr)
  );

  cv32e40p_irq_gateway #(.NUM_IRQ(20), .SYNC_STAGES(S)) dut20 (
    .clk          (clk),
    .rst          (rst),
    .irq_raw_i    (raw[19:0]),
    .trig_edge_i  (trig[19:0]),
    .irq_ack_i    (ack),
    .irq_ack_id_i (ack_id),
    .sw_set_i     (sw_set),
    .sw_clr_i     (sw_clr),
    .sw_id_i      (sw_id),
    .irq_o        (irq20),
    .overrun_o    (ovr20)
  );

  // Behavioural model: raw samples history, per-line pending/overrun flags.
  bit [31:0] m_samp [3];
  bit [31:0] m_hist, m_pend, m_ovr, m_trig;
  bit [31:0] m_sync, m_np, m_no;
  bit        m_chg, m_rise, m_set, m_clr;
  int        m_age;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) m_samp[k] = '0;
      m_hist = '0; m_pend = '0; m_ovr = '0; m_trig = '0; m_age = 0;
    end else begin
      m_sync = m_samp[S-1];
      m_np   = m_pend;
      m_no   = m_ovr;
      for (int i = 0; i < 32; i++) begin
        if (MASK_REF[i]) begin
          m_chg  = (trig[i] != m_trig[i]);
          m_rise = m_sync[i] && !m_hist[i] && !m_chg && (m_age > S);
          m_set  = m_rise || (sw_set && sw_id == 5'(i));
          m_clr  = (ack && ack_id == 5'(i)) || (sw_clr && sw_id == 5'(i));
          if (m_chg || !m_trig[i]) begin
            m_np[i] = 1'b0;
            m_no[i] = 1'b0;
          end else begin
            m_np[i] = m_set ? 1'b1 : (m_clr ? 1'b0 : m_pend[i]);
            if (m_rise && m_pend[i] && !m_clr) m_no[i] = 1'b1;
            else if (sw_clr && sw_id == 5'(i)) m_no[i] = 1'b0;
          end
        end
      end
      m_pend    = m_np;
      m_ovr     = m_no;
      m_hist    = m_sync;
      m_trig    = trig & MASK_REF;
      m_samp[2] = m_samp[1];
      m_samp[1] = m_samp[0];
      m_samp[0] = raw & MASK_REF;
      if (m_age < 100) m_age++;
    end
  end

  function automatic logic [31:0] model_irq();
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = m_trig[i] ? m_pend[i] : m_samp[S-1][i];
    return r;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; raw = '1; trig = '1;
    ack = 1'b0; ack_id = '0; sw_set = 1'b0; sw_clr = 1'b0; sw_id = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (irq !== 32'h0 || ovr !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_hold irq=%h ovr=%h expected 0/0", irq, ovr);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (irq !== 32'h0 || ovr !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_release cyc=%0d irq=%h ovr=%h expected 0/0", c, irq, ovr);
      end
    end
    raw = '0;
    tick(4);
  endtask

  task automatic test_edge_latch();
    raw[11] = 1'b1;
    tick(2);
    checks++;
    if (irq[11] !== 1'b0) begin
      failures++; $display("[TB] FAIL edge_latency_early irq11=%b expected 0", irq[11]);
    end
    tick();
    checks++;
    if (irq[11] !== 1'b1) begin
      failures++; $display("[TB] FAIL edge_latch_set irq11=%b expected 1", irq[11]);
    end
    raw[11] = 1'b0;
    tick(4);
    checks++;
    if (irq[11] !== 1'b1) begin
      failures++; $display("[TB] FAIL edge_sticky irq11=%b expected 1", irq[11]);
    end
    ack = 1'b1; ack_id = 5'd11;
    tick();
    ack = 1'b0;
    checks++;
    if (irq !== 32'h0) begin
      failures++; $display("[TB] FAIL edge_ack_clear irq=%h expected 00000000", irq);
    end
  endtask

  task automatic test_set_beats_ack();
    raw[16] = 1'b1;
    tick(3);
    checks++;
    if (irq[16] !== 1'b1) begin
      failures++; $display("[TB] FAIL sba_first_edge irq16=%b expected 1", irq[16]);
    end
    raw[16] = 1'b0;
    tick(3);
    raw[16] = 1'b1;
    tick(2);
    ack = 1'b1; ack_id = 5'd16;
    tick();
    ack = 1'b0;
    checks++;
    if (irq[16] !== 1'b1 || ovr[16] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL set_beats_ack irq16=%b ovr16=%b expected 1/0", irq[16], ovr[16]);
    end
    ack = 1'b1; ack_id = 5'd16;
    tick();
    ack = 1'b0;
    checks++;
    if (irq[16] !== 1'b0) begin
      failures++; $display("[TB] FAIL sba_cleanup irq16=%b expected 0", irq[16]);
    end
  endtask

  task automatic test_overrun();
    raw[7] = 1'b1;
    tick(3);
    checks++;
    if (irq[7] !== 1'b1 || ovr[7] !== 1'b0) begin
      failures++; $display("[TB] FAIL ovr_first irq7=%b ovr7=%b expected 1/0", irq[7], ovr[7]);
    end
    raw[7] = 1'b0;
    tick(3);
    raw[7] = 1'b1;
    tick(3);
    checks++;
    if (irq[7] !== 1'b1 || ovr[7] !== 1'b1) begin
      failures++; $display("[TB] FAIL ovr_set irq7=%b ovr7=%b expected 1/1", irq[7], ovr[7]);
    end
    sw_clr = 1'b1; sw_id = 5'd7;
    tick();
    sw_clr = 1'b0;
    checks++;
    if (irq[7] !== 1'b0 || ovr[7] !== 1'b0) begin
      failures++; $display("[TB] FAIL ovr_sw_clear irq7=%b ovr7=%b expected 0/0", irq[7], ovr[7]);
    end
  endtask

  task automatic test_level_mode();
    trig[3] = 1'b0;
    tick(2);
    raw[3] = 1'b1;
    tick();
    checks++;
    if (irq[3] !== 1'b0) begin
      failures++; $display("[TB] FAIL level_early irq3=%b expected 0", irq[3]);
    end
    tick();
    checks++;
    if (irq[3] !== 1'b1) begin
      failures++; $display("[TB] FAIL level_pass irq3=%b expected 1", irq[3]);
    end
    ack = 1'b1; ack_id = 5'd3;
    tick();
    ack = 1'b0;
    sw_clr = 1'b1; sw_id = 5'd3;
    tick();
    sw_clr = 1'b0;
    checks++;
    if (irq[3] !== 1'b1 || ovr[3] !== 1'b0) begin
      failures++; $display("[TB] FAIL level_ignore_strobes irq3=%b ovr3=%b expected 1/0", irq[3], ovr[3]);
    end
    trig[3] = 1'b1;
    tick();
    checks++;
    if (irq[3] !== 1'b0) begin
      failures++; $display("[TB] FAIL mode_switch irq3=%b expected 0", irq[3]);
    end
    tick(3);
    checks++;
    if (irq[3] !== 1'b0) begin
      failures++; $display("[TB] FAIL mode_no_redetect irq3=%b expected 0", irq[3]);
    end
    raw[3] = 1'b0;
    tick(3);
    raw[3] = 1'b1;
    tick(3);
    checks++;
    if (irq[3] !== 1'b1) begin
      failures++; $display("[TB] FAIL mode_new_edge irq3=%b expected 1", irq[3]);
    end
  endtask

  task automatic test_masked();
    sw_set = 1'b1; sw_id = 5'd25;
    tick();
    sw_set = 1'b0;
    checks++;
    if (irq20 !== 20'h00008 || ovr20 !== 20'h0) begin
      failures++; $display("[TB] FAIL out_of_range irq20=%h ovr20=%h expected 00008/00000", irq20, ovr20);
    end
    sw_set = 1'b1; sw_id = 5'd12;
    tick();
    sw_set = 1'b0;
    checks++;
    if (irq20[12] !== 1'b0 || irq[12] !== 1'b0) begin
      failures++; $display("[TB] FAIL masked_id irq20_12=%b irq12=%b expected 0/0", irq20[12], irq[12]);
    end
    sw_set = 1'b1; sw_id = 5'd17;
    tick();
    sw_set = 1'b0;
    checks++;
    if (irq20 !== 20'h20008 || irq[17] !== 1'b1) begin
      failures++; $display("[TB] FAIL sw_set_valid irq20=%h irq17=%b expected 20008/1", irq20, irq[17]);
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      raw = raw ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 19) == 0) trig[$urandom_range(0, 31)] ^= 1'b1;
      ack    = ($urandom_range(0, 3) == 0);
      ack_id = 5'($urandom_range(0, 31));
      sw_set = ($urandom_range(0, 7) == 0);
      sw_clr = ($urandom_range(0, 7) == 0);
      sw_id  = 5'($urandom_range(0, 31));
      tick();
      checks++;
      if (irq !== model_irq() || ovr !== m_ovr) begin
        failures++;
        $display("[TB] FAIL random cyc=%0d irq=%h ovr=%h expected %h/%h", c, irq, ovr, model_irq(), m_ovr);
      end
    end
    ack = 1'b0; sw_set = 1'b0; sw_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_latch();
    test_set_beats_ack();
    test_overrun();
    test_level_mode();
    test_masked();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
